// File: rtl/axi_burst_pkg.sv
// Shared types and AXI encodings for the capture-buffer burst writer.
package axi_burst_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Frame-buffer write pointer: steps one burst per acknowledged burst and
// folds back to the frame base at end of frame, flagging the wrap for one cycle.
module frame_addr_gen
    import axi_burst_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE  = 'h1000_0000,
    parameter int                    FRAME_BYTES = 614400,
    parameter int                    BURST_BYTES = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  advance_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  wrap_o
);

    localparam logic [ADDR_WIDTH-1:0] FRAME_END = FRAME_BASE + ADDR_WIDTH'(FRAME_BYTES);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
    logic                  wrap_q, wrap_d;

    // Exact-equality wrap: an aligned frame lands precisely on FRAME_END.
    always_comb begin
        addr_inc = addr_q + ADDR_WIDTH'(BURST_BYTES);
        addr_d   = addr_q;
        wrap_d   = 1'b0;
        if (advance_i) begin
            if (addr_inc == FRAME_END) begin
                addr_d = FRAME_BASE;
                wrap_d = 1'b1;
            end else begin
                addr_d = addr_inc;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= FRAME_BASE;
            wrap_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            wrap_q <= wrap_d;
        end
    end

    assign addr_o = addr_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/axi_burst_writer.sv
// Drains the capture FIFO (FWFT read side) into fixed-length AXI4 INCR
// write bursts, walking a single frame buffer in DDR.
module axi_burst_writer
    import axi_burst_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    CNT_WIDTH   = 9,
    parameter int                    BURST_LEN   = 16,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE  = 'h1000_0000,
    parameter int                    FRAME_BYTES = 614400
) (
    input  logic                    clk_100Mhz,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [DATA_WIDTH-1:0]   fifo_dout,
    input  logic                    fifo_empty,
    input  logic [CNT_WIDTH-1:0]    fifo_rd_data_count,
    output logic                    fifo_rd_en,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err
);

    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;

    state_e     state_q, state_d;
    logic [7:0] beat_q, beat_d;
    logic       err_q, err_d;
    logic       advance, w_hs, last_beat;

    assign last_beat = (beat_q == 8'(BURST_LEN - 1));
    assign w_hs      = m_axi_wvalid & m_axi_wready;

    // The launch test uses the synchronised count, which only ever under-reports.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        err_d   = err_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE: if (enable && fifo_rd_data_count >= CNT_WIDTH'(BURST_LEN)) state_d = S_ADDR;
            S_ADDR: if (m_axi_awready) state_d = S_DATA;
            S_DATA: begin
                if (w_hs) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = S_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    advance = 1'b1;
                    if (m_axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    frame_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .FRAME_BASE (FRAME_BASE),
        .FRAME_BYTES(FRAME_BYTES),
        .BURST_BYTES(BURST_BYTES)
    ) u_addr (
        .clk_i    (clk_100Mhz),
        .rst_i    (rst),
        .advance_i(advance),
        .addr_o   (m_axi_awaddr),
        .wrap_o   (frame_done)
    );

    // Channel strobes decode straight from the state register, so awvalid
    // and bready are registered and never depend on the slave's ready.
    assign m_axi_awvalid = (state_q == S_ADDR);
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = axi_size(DATA_WIDTH);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wvalid  = (state_q == S_DATA) & ~fifo_empty;
    assign m_axi_wdata   = fifo_dout;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state_q == S_DATA) & last_beat;
    assign m_axi_bready  = (state_q == S_RESP);
    assign fifo_rd_en    = w_hs;
    assign busy          = (state_q != S_IDLE);
    assign err           = err_q;

endmodule
